// File: rtl/ibex_compressed_packer.sv
// RV32I -> RVC compressor feeding a 3-halfword buffer that emits aligned 32-bit words.
// Optional compressed-instruction counter enabled by IBEX_CPACK_STATS_EN.
module ibex_compressed_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] word_o,
  output logic        illegal_o
`ifdef IBEX_CPACK_STATS_EN
  ,
  output logic [15:0] cmp_count_o
`endif
);

  typedef enum logic {RUN, DRAIN} state_e;

  state_e            state_q, state_n;
  logic [1:0]        count_q, count_n;
  logic [2:0][15:0]  hw_buf_q, hw_buf_n;
  logic              illegal_q;

  // Instruction field decode
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] imm_i, imm_s;
  logic        is_addi, is_add, is_lw, is_sw;
  logic        imm_small, lw_off_ok, sw_off_ok;
  logic        rd_c, rs1_c, rs2_c;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign funct7 = instr_i[31:25];
  assign imm_i  = instr_i[31:20];
  assign imm_s  = {instr_i[31:25], instr_i[11:7]};

  assign is_addi = (opcode == 7'h13) && (funct3 == 3'b000);
  assign is_add  = (opcode == 7'h33) && (funct3 == 3'b000) && (funct7 == 7'h00);
  assign is_lw   = (opcode == 7'h03) && (funct3 == 3'b010);
  assign is_sw   = (opcode == 7'h23) && (funct3 == 3'b010);

  // A 6-bit signed immediate means bits [11:5] are all copies of the sign
  assign imm_small = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7F);
  assign lw_off_ok = (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'b00);
  assign sw_off_ok = (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'b00);

  assign rd_c  = (rd[4:3]  == 2'b01);
  assign rs1_c = (rs1[4:3] == 2'b01);
  assign rs2_c = (rs2[4:3] == 2'b01);

  logic        enc_size2;
  logic [31:0] enc_hw;

  always_comb begin
    enc_size2 = 1'b1;
    enc_hw    = instr_i;
    if (instr_i == 32'h0000_0013) begin
      enc_size2 = 1'b0;
      enc_hw    = 32'h0000_0001;
    end else if (is_addi && (rd == rs1) && (rd != 5'd0) && imm_small && (imm_i != 12'd0)) begin
      enc_size2 = 1'b0;
      enc_hw    = {16'h0000, 3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
    end else if (is_addi && (rd != 5'd0) && (rs1 == 5'd0) && imm_small) begin
      enc_size2 = 1'b0;
      enc_hw    = {16'h0000, 3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
    end else if (is_add && (rd != 5'd0) && (rs1 == 5'd0) && (rs2 != 5'd0)) begin
      enc_size2 = 1'b0;
      enc_hw    = {16'h0000, 4'b1000, rd, rs2, 2'b10};
    end else if (is_add && (rd == rs1) && (rd != 5'd0) && (rs2 != 5'd0)) begin
      enc_size2 = 1'b0;
      enc_hw    = {16'h0000, 4'b1001, rd, rs2, 2'b10};
    end else if (is_lw && rd_c && rs1_c && lw_off_ok) begin
      enc_size2 = 1'b0;
      enc_hw    = {16'h0000, 3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
    end else if (is_sw && rs2_c && rs1_c && sw_off_ok) begin
      enc_size2 = 1'b0;
      enc_hw    = {16'h0000, 3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
    end
  end

  // Handshakes: illegal instructions are consumed but never enter the buffer
  logic legal, accept, push, pop;

  assign legal       = (instr_i[1:0] == 2'b11);
  assign accept      = in_valid_i & in_ready_o;
  assign push        = accept & legal;
  assign out_valid_o = (count_q >= 2'd2);
  assign pop         = out_valid_o & out_ready_i;
  assign word_o      = {hw_buf_q[1], hw_buf_q[0]};
  assign illegal_o   = illegal_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    in_ready_o = 1'b0;
    unique case (state_q)
      RUN: begin
        in_ready_o = (count_q <= 2'd1) | out_ready_i;
        if (flush_i) state_n = DRAIN;
      end
      DRAIN: begin
        if (count_q == 2'd0) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  logic [1:0] base;
  logic [1:0] add;

  always_comb begin
    hw_buf_n = hw_buf_q;
    base     = count_q;
    add      = enc_size2 ? 2'd2 : 2'd1;
    if (pop) begin
      hw_buf_n[0] = hw_buf_q[2];
      hw_buf_n[1] = 16'h0000;
      hw_buf_n[2] = 16'h0000;
      base        = count_q - 2'd2;
    end
    for (int i = 0; i < 3; i++) begin
      if (push && (2'(i) == base))
        hw_buf_n[i] = enc_hw[15:0];
      if (push && enc_size2 && (2'(i) == base + 2'd1))
        hw_buf_n[i] = enc_hw[31:16];
    end
    count_n = base + (push ? add : 2'd0);
    // Odd trailing halfword is padded with C.NOP so it can leave as a full word
    if ((state_q == DRAIN) && (count_q == 2'd1)) begin
      hw_buf_n[1] = 16'h0001;
      count_n     = 2'd2;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q   <= 2'd0;
      hw_buf_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      count_q   <= count_n;
      hw_buf_q  <= hw_buf_n;
      illegal_q <= accept & ~legal;
    end
  end

`ifdef IBEX_CPACK_STATS_EN
  logic [15:0] cmp_count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmp_count_q <= 16'd0;
    end else if (push && !enc_size2 && (cmp_count_q != 16'hFFFF)) begin
      cmp_count_q <= cmp_count_q + 16'd1;
    end
  end

  assign cmp_count_o = cmp_count_q;
`endif

endmodule
